// File: rtl/mux_4x1_pkg.sv
// Shared lane count, default byte width and lane index type for the 4:1 reassembly mux.
package mux_4x1_pkg;
    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    typedef logic [1:0] lane_idx_t;
endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO; DEPTH must be a power of two so pointers wrap for free.
module lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mux_4x1_8bits.sv
// Reassembles a round-robin 1x4 demuxed byte stream: one FIFO per lane, drained strictly 0,1,2,3.
module mux_4x1_8bits
    import mux_4x1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = DATA_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [WIDTH-1:0] In3,
    input  logic             validIn0,
    input  logic             validIn1,
    input  logic             validIn2,
    input  logic             validIn3,
    output logic             ready0,
    output logic             ready1,
    output logic             ready2,
    output logic             ready3,
    output logic [WIDTH-1:0] data_out,
    output logic             validOut,
    output logic [1:0]       lane_sel,
    output logic             overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [LANES-1:0][WIDTH-1:0] lane_din, lane_head;
    logic [LANES-1:0][CW-1:0]    lane_cnt;
    logic [LANES-1:0]            lane_vld, lane_rdy, lane_full, lane_empty;
    logic [LANES-1:0]            lane_push, lane_pop, lane_drop;
    logic                        head_ok;

    assign lane_din = {In3, In2, In1, In0};
    assign lane_vld = {validIn3, validIn2, validIn1, validIn0};
    assign {ready3, ready2, ready1, ready0} = lane_rdy;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Ready and drop both come from the registered count, so a pop on the
        // same edge never frees room for the incoming byte.
        assign lane_rdy[g]  = (lane_cnt[g] < CW'(FIFO_DEPTH));
        assign lane_push[g] = lane_vld[g] & lane_rdy[g];
        assign lane_drop[g] = lane_vld[g] & lane_full[g];
        assign lane_pop[g]  = (lane_sel == lane_idx_t'(g)) & ~lane_empty[g];

        lane_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WIDTH)) u_fifo (
            .clk     (clk),
            .reset_L (reset_L),
            .push    (lane_push[g]),
            .pop     (lane_pop[g]),
            .din     (lane_din[g]),
            .head    (lane_head[g]),
            .count   (lane_cnt[g]),
            .full    (lane_full[g]),
            .empty   (lane_empty[g])
        );
    end

    assign head_ok = ~lane_empty[lane_sel];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            lane_sel <= '0;
            data_out <= '0;
            validOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (head_ok) begin
                data_out <= lane_head[lane_sel];
                validOut <= 1'b1;
                lane_sel <= lane_sel + 1'b1;
            end else begin
                validOut <= 1'b0;
            end
            if (|lane_drop) overflow <= 1'b1;
        end
    end
endmodule
